// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int                 INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous in-order buffer of fetched {pc, instr} entries.
// Flush wins over push and pop in the same cycle.
module if_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, in-order response buffering
// and redirect flushing. Optional misaligned-redirect fault/halt via IF_MISALIGN_CHK_EN.
module if_stage
    import if_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [INSTR_W-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [INSTR_W-1:0] id_pc,
    output logic               if_fault
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if_state_e          state_q;
    if_state_e          state_d;
    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] pc_d;
    logic [CNT_W-1:0]   inflight_q;
    logic [CNT_W-1:0]   inflight_d;
    logic [CNT_W-1:0]   drop_q;
    logic [CNT_W-1:0]   drop_d;
    logic [INSTR_W-1:0] tag_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   tag_wr_q;
    logic [PTR_W-1:0]   tag_rd_q;
    logic               req_fire;
    logic               credit_ok;
    logic               misalign;
    logic               fifo_flush;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;

    // Outstanding requests plus buffered entries may never exceed the buffer size.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign imem_req_addr = pc_q;

`ifdef IF_MISALIGN_CHK_EN
    logic fault_q;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign if_fault = fault_q;

    always_ff @(posedge clk) begin
        if (rst)           fault_q <= 1'b0;
        else if (misalign) fault_q <= 1'b1;
    end
`else
    assign misalign = 1'b0;
    assign if_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            BOOT:    state_d = misalign ? HALT : FETCH;
            FETCH:   state_d = misalign ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        fifo_flush     = redirect_valid;
        case (state_q)
            FETCH:   imem_req_valid = credit_ok;
            HALT:    fifo_flush     = 1'b1;
            default: imem_req_valid = 1'b0;
        endcase
    end

    always_comb begin
        if (redirect_valid) pc_d = align_pc(redirect_pc);
        else if (req_fire)  pc_d = pc_q + 32'd4;
        else                pc_d = pc_q;
        case ({req_fire, imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        // Everything still in flight after a redirect belongs to the old stream.
        if (redirect_valid)                          drop_d = inflight_d;
        else if (imem_rsp_valid && drop_q != '0)     drop_d = drop_q - CNT_W'(1);
        else                                         drop_d = drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            if (req_fire)       tag_wr_q <= tag_wr_q + PTR_W'(1);
            if (imem_rsp_valid) tag_rd_q <= tag_rd_q + PTR_W'(1);
        end
    end

    // Request PCs, consumed in order by responses (including dropped ones).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) tag_q[i] <= '0;
        end else if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
    end

    assign push_entry.pc    = tag_q[tag_rd_q];
    assign push_entry.instr = imem_rsp_data;
    assign fifo_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid && !fifo_full;
    assign fifo_pop  = id_valid && id_ready;

    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign id_valid = !fifo_empty;
    assign id_instr = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign id_pc    = fifo_empty ? 32'h0000_0000 : head_entry.pc;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: an in-order imem model with variable latency and a
// stream-level reference (epochs per redirect) checked against the DUT every cycle.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        if_fault;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .if_fault       (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    pend_t       pend[$];
    ent_t        expq[$];
    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_in[$];
    int          epoch    = 0;
    int          m_st     = 0;
    logic [31:0] m_pc     = RST_PC;
    logic        m_fault  = 1'b0;

    int          ready_pct = 100;
    int          rsp_pct   = 100;
    int          idr_pct   = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          redir_pm  = 0;
    int          force_idr = 1;
    bit          force_redir = 1'b0;
    bit          force_rsp   = 1'b0;
    logic [31:0] force_pc    = 32'h0;

    function automatic logic [31:0] imem_data(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] get_req(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_dpc(input int i);
        return (i < dlv_pc.size()) ? dlv_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_din(input int i);
        return (i < dlv_in.size()) ? dlv_in[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"},  imem_req_addr, RST_PC);
        check({tag, "_id_valid"},  32'(id_valid), 32'd0);
        check({tag, "_id_instr"},  id_instr, NOP);
        check({tag, "_id_pc"},     id_pc, 32'h0);
        check({tag, "_if_fault"},  32'(if_fault), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        repeat (n) begin
            @(posedge clk); @(negedge clk); cyc++;
        end
        rst = 1'b0;
        pend.delete(); expq.delete();
        epoch++; m_st = 0; m_pc = RST_PC; m_fault = 1'b0;
    endtask

    // One cycle: compare DUT against the model, drive inputs, advance the model.
    task automatic step();
        logic        exp_rv, exp_iv, rdy, rv, idr, redir, deliver, fire;
        logic [31:0] rdata, tgt;
        pend_t       p;
        exp_rv = (m_st == 1) && ((pend.size() + expq.size()) < 2);
        exp_iv = (expq.size() != 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(exp_iv));
        if (exp_iv) begin
            check("id_pc", id_pc, expq[0].pc);
            check("id_instr", id_instr, expq[0].instr);
        end
        check("if_fault", 32'(if_fault), 32'(m_fault));

        rdy   = ($urandom_range(99) < 32'(ready_pct));
        rv    = 1'b0;
        rdata = 32'h0;
        if (pend.size() != 0 && pend[0].due <= cyc && (force_rsp || $urandom_range(99) < 32'(rsp_pct))) begin
            rv    = 1'b1;
            rdata = imem_data(pend[0].addr);
        end
        idr   = (force_idr >= 0) ? (force_idr != 0) : ($urandom_range(99) < 32'(idr_pct));
        redir = force_redir || (m_st == 1 && $urandom_range(999) < 32'(redir_pm));
        tgt   = force_redir ? force_pc
              : (($urandom_range(1) != 0) ? 32'hFFFF_FF00 : 32'h0000_1000) + (32'($urandom_range(63)) << 2);
        force_redir = 1'b0;
        force_rsp   = 1'b0;

        imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rdata;
        id_ready = idr; redirect_valid = redir; redirect_pc = tgt;
        if (imem_req_valid && rdy) req_log.push_back(imem_req_addr);
        if (id_valid && idr && !redir) begin
            dlv_pc.push_back(id_pc);
            dlv_in.push_back(id_instr);
        end

        fire    = exp_rv && rdy;
        deliver = 1'b0;
        p       = '{32'h0, 0, 0};
        if (rv) begin
            p = pend.pop_front();
            deliver = !redir && (p.epoch == epoch) && (m_st != 2);
        end
        if (exp_iv && idr && !redir) void'(expq.pop_front());
        if (deliver) expq.push_back('{p.addr, imem_data(p.addr)});
        if (fire) begin
            pend.push_back('{m_pc, epoch, cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)))});
            m_pc = m_pc + 32'd4;
        end
        if (m_st == 0) m_st = 1;
        if (redir) begin
            expq.delete();
            epoch++;
            m_pc = tgt & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_CHK_EN
            if (tgt[1:0] != 2'b00) begin
                m_st = 2;
                m_fault = 1'b1;
            end
`endif
        end
        if (m_st == 2) expq.delete();
        @(posedge clk); @(negedge clk); cyc++;
    endtask

    initial begin
        int mark;
        int k;
        do_reset(3);
        reset_checks("rst0");

        // Sequential fetch, always-ready imem with 1-cycle latency.
        repeat (30) step();
        check("t1_req0", get_req(0), 32'h0);
        check("t1_req1", get_req(1), 32'h4);
        check("t1_req2", get_req(2), 32'h8);
        check("t1_dlv0", get_dpc(0), 32'h0);
        check("t1_dlv1", get_dpc(1), 32'h4);
        check("t1_dlv2", get_dpc(2), 32'h8);
        check("t1_ins0", get_din(0), 32'h1357_9BDF);

        // Decode stall for 6 cycles, then drain.
        lat_max = 2; force_idr = 0;
        repeat (6) step();
        check("t2_stalled_valid", 32'(id_valid), 32'd1);
        force_idr = 1;
        mark = dlv_pc.size();
        repeat (15) step();
        check("t2_order", get_dpc(mark + 1), get_dpc(mark) + 32'd4);

        // Redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        k = 0;
        while (pend.size() != 2 && k < 20) begin step(); k++; end
        check("t3_two_inflight", 32'(pend.size()), 32'd2);
        force_redir = 1'b1; force_pc = 32'h0000_0100;
        step();
        mark = dlv_pc.size();
        repeat (20) step();
        check("t3_first_pc", get_dpc(mark), 32'h100);
        check("t3_second_pc", get_dpc(mark + 1), 32'h104);
        check("t3_first_ins", get_din(mark), imem_data(32'h100));

        // Redirect coinciding with a pop and a response.
        lat_min = 1; lat_max = 1;
        k = 0;
        while (!(expq.size() != 0 && pend.size() != 0 && pend[0].due <= cyc) && k < 30) begin step(); k++; end
        check("t4_setup", 32'(expq.size() != 0 && pend.size() != 0), 32'd1);
        force_redir = 1'b1; force_pc = 32'h0000_0200; force_rsp = 1'b1;
        step();
        check("t4_id_valid_after", 32'(id_valid), 32'd0);
        mark = dlv_pc.size();
        repeat (20) step();
        check("t4_next_pc", get_dpc(mark), 32'h200);

        // PC wrap at the top of the address space.
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        step();
        mark = req_log.size();
        repeat (12) step();
        check("wrap_req0", get_req(mark), 32'hFFFF_FFF8);
        check("wrap_req1", get_req(mark + 1), 32'hFFFF_FFFC);
        check("wrap_req2", get_req(mark + 2), 32'h0);

        // Randomized traffic with occasional redirects.
        ready_pct = 70; rsp_pct = 60; idr_pct = 60; lat_min = 1; lat_max = 4;
        redir_pm = 30; force_idr = -1;
        repeat (600) step();

        // Reset mid-stream.
        do_reset(1);
        reset_checks("rst_mid");
        step();
        check("t5_first_valid", 32'(imem_req_valid), 32'd1);
        check("t5_first_addr", imem_req_addr, RST_PC);
        ready_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 1; redir_pm = 0; force_idr = 1;
        repeat (20) step();

        // Misaligned redirect.
        force_redir = 1'b1; force_pc = 32'h0000_0102;
        step();
`ifdef IF_MISALIGN_CHK_EN
        repeat (20) step();
        check("t6_fault", 32'(if_fault), 32'd1);
        check("t6_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_id_valid", 32'(id_valid), 32'd0);
        do_reset(2);
        reset_checks("rst_halt");
        repeat (10) step();
`else
        mark = req_log.size();
        repeat (10) step();
        check("t6_resume_addr", get_req(mark), 32'h100);
        check("t6_no_fault", 32'(if_fault), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
